me_search_ctrl: RTL and testbench



---
 rtl/me_search_ctrl.sv | 164 ++++++++++++++++
 tb/tb_me_search_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/me_search_ctrl.sv
// me_search_ctrl: sequences one coarse search and up to MAX_ITER 4-neighbour integer refinements.
// Optional feature macro ME_ITER_CNT_EN adds the iter_cnt output (iterations of the last run).
module me_search_ctrl #(
    parameter int CMV_W     = 5,
    parameter int MV_W      = 6,
    parameter int SAD_W     = 16,
    parameter int DEC_SHIFT = 1,
    parameter int SR        = 15,
    parameter int MAX_ITER  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req,
    output logic               ack,
    output logic [SAD_W-1:0]   min_sad,
    output logic [2*MV_W-1:0]  min_mvec,
    output logic               req_d,
    input  logic [2*CMV_W-1:0] min_mvec_d,
    input  logic               ack_d,
    output logic               req_i,
    output logic [2*MV_W-1:0]  init_pos_i,
    input  logic [SAD_W-1:0]   min_sad_i,
    input  logic [3:0]         min_diff_i,
    input  logic               ack_i
`ifdef ME_ITER_CNT_EN
    ,
    output logic [3:0]         iter_cnt
`endif
);

    localparam int EW = MV_W + DEC_SHIFT + 1;
    localparam logic signed [EW-1:0] SR_E   = EW'(SR);
    localparam logic signed [MV_W:0] SR_F   = (MV_W + 1)'(SR);
    localparam logic signed [MV_W:0] ONE_F  = (MV_W + 1)'(1);
    localparam logic [3:0]           MAX_IT = 4'(MAX_ITER);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        C_REQ  = 3'd1,
        C_WAIT = 3'd2,
        F_REQ  = 3'd3,
        F_WAIT = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t     state_r;
    logic [3:0] iter_r;

    // Coarse component -> integer units, saturated to the search window.
    function automatic logic signed [MV_W-1:0] sat_comp(input logic signed [CMV_W-1:0] c);
        logic signed [EW-1:0] w;
        w = EW'(c) <<< DEC_SHIFT;
        if (w > SR_E) begin
            sat_comp = MV_W'(SR);
        end else if (w < -SR_E) begin
            sat_comp = MV_W'(-SR);
        end else begin
            sat_comp = w[MV_W-1:0];
        end
    endfunction

    logic signed [MV_W-1:0] pos_y_s, pos_x_s;
    logic signed [MV_W:0]   dy_s, dx_s, ny_s, nx_s;
    logic                   sup_s, term_s;
    logic [3:0]             iter_nx_s;
    logic [2*MV_W-1:0]      start_pos_s, next_pos_s;

    assign pos_y_s = init_pos_i[2*MV_W-1:MV_W];
    assign pos_x_s = init_pos_i[MV_W-1:0];

    // Start position from the coarse result, plus the step decode for the current fine ack.
    always_comb begin
        start_pos_s = {sat_comp(min_mvec_d[2*CMV_W-1:CMV_W]), sat_comp(min_mvec_d[CMV_W-1:0])};
        dy_s = '0;
        dx_s = '0;
        if (min_diff_i[3]) begin
            dy_s = -ONE_F;
        end else if (min_diff_i[2]) begin
            dy_s = ONE_F;
        end else if (min_diff_i[1]) begin
            dx_s = -ONE_F;
        end else if (min_diff_i[0]) begin
            dx_s = ONE_F;
        end else begin
            dx_s = '0;
        end
        ny_s = (MV_W + 1)'(pos_y_s) + dy_s;
        nx_s = (MV_W + 1)'(pos_x_s) + dx_s;
        sup_s = (ny_s > SR_F) || (ny_s < -SR_F) || (nx_s > SR_F) || (nx_s < -SR_F);
        if (sup_s) begin
            next_pos_s = init_pos_i;
        end else begin
            next_pos_s = {ny_s[MV_W-1:0], nx_s[MV_W-1:0]};
        end
        iter_nx_s = iter_r + 4'd1;
        term_s    = (min_diff_i == 4'd0) || sup_s || (iter_nx_s == MAX_IT);
    end

    // Control FSM with registered pulses and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            iter_r     <= 4'd0;
            ack        <= 1'b0;
            req_d      <= 1'b0;
            req_i      <= 1'b0;
            min_sad    <= '0;
            min_mvec   <= '0;
            init_pos_i <= '0;
`ifdef ME_ITER_CNT_EN
            iter_cnt   <= 4'd0;
`endif
        end else begin
            ack   <= 1'b0;
            req_d <= 1'b0;
            req_i <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (req) begin
                        req_d   <= 1'b1;
                        state_r <= C_REQ;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                C_REQ: state_r <= C_WAIT;
                C_WAIT: begin
                    if (ack_d) begin
                        init_pos_i <= start_pos_s;
                        iter_r     <= 4'd0;
                        req_i      <= 1'b1;
                        state_r    <= F_REQ;
                    end else begin
                        state_r <= C_WAIT;
                    end
                end
                F_REQ: state_r <= F_WAIT;
                F_WAIT: begin
                    if (ack_i) begin
                        iter_r     <= iter_nx_s;
                        init_pos_i <= next_pos_s;
                        if (term_s) begin
                            ack      <= 1'b1;
                            min_mvec <= next_pos_s;
                            min_sad  <= min_sad_i;
`ifdef ME_ITER_CNT_EN
                            iter_cnt <= iter_nx_s;
`endif
                            state_r  <= DONE;
                        end else begin
                            req_i   <= 1'b1;
                            state_r <= F_REQ;
                        end
                    end else begin
                        state_r <= F_WAIT;
                    end
                end
                DONE:    state_r <= IDLE;
                default: state_r <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_me_search_ctrl.sv
// Randomised self-checking bench for me_search_ctrl with an integer-arithmetic reference model.
`timescale 1ns/1ps
module tb_me_search_ctrl;
    localparam int CMV_W = 5, MV_W = 6, SAD_W = 16, DEC_SHIFT = 1, SR = 15, MAX_ITER = 4;

    logic               clk, rst_n, req, ack, req_d, ack_d, req_i, ack_i;
    logic [SAD_W-1:0]   min_sad, min_sad_i;
    logic [2*MV_W-1:0]  min_mvec, init_pos_i;
    logic [2*CMV_W-1:0] min_mvec_d;
    logic [3:0]         min_diff_i;
`ifdef ME_ITER_CNT_EN
    logic [3:0]         iter_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int dut_nreq = 0;

    logic              e_req_d = 1'b0, e_req_i = 1'b0, e_ack = 1'b0, e_fine = 1'b0;
    logic [2*MV_W-1:0] e_pos = '0, e_mvec = '0;
    logic [SAD_W-1:0]  e_sad = '0;
    logic [3:0]        e_iter = 4'd0;
    logic [3:0]        diff_q[$];
    int                sad_q[$];

    me_search_ctrl #(.CMV_W(CMV_W), .MV_W(MV_W), .SAD_W(SAD_W), .DEC_SHIFT(DEC_SHIFT),
                     .SR(SR), .MAX_ITER(MAX_ITER)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .ack(ack), .min_sad(min_sad),
        .min_mvec(min_mvec), .req_d(req_d), .min_mvec_d(min_mvec_d), .ack_d(ack_d),
        .req_i(req_i), .init_pos_i(init_pos_i), .min_sad_i(min_sad_i),
        .min_diff_i(min_diff_i), .ack_i(ack_i)
`ifdef ME_ITER_CNT_EN
        , .iter_cnt(iter_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model expectations.
    always @(negedge clk) begin
        chk("req_d", 32'(req_d), 32'(e_req_d));
        chk("req_i", 32'(req_i), 32'(e_req_i));
        chk("ack", 32'(ack), 32'(e_ack));
        chk("min_mvec", 32'(min_mvec), 32'(e_mvec));
        chk("min_sad", 32'(min_sad), 32'(e_sad));
        if (e_fine) chk("init_pos_i", 32'(init_pos_i), 32'(e_pos));
`ifdef ME_ITER_CNT_EN
        chk("iter_cnt", 32'(iter_cnt), 32'(e_iter));
`endif
        if (req_i) dut_nreq++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2*MV_W-1:0] pk(input int y, input int x);
        logic [MV_W-1:0] yy, xx;
        yy = y[MV_W-1:0];
        xx = x[MV_W-1:0];
        return {yy, xx};
    endfunction

    function automatic logic [2*CMV_W-1:0] pkc(input int y, input int x);
        logic [CMV_W-1:0] yy, xx;
        yy = y[CMV_W-1:0];
        xx = x[CMV_W-1:0];
        return {yy, xx};
    endfunction

    function automatic int clampc(input int c);
        int v;
        v = c * (1 << DEC_SHIFT);
        if (v > SR) return SR;
        if (v < -SR) return -SR;
        return v;
    endfunction

    function automatic logic [3:0] rand_diff();
        int r;
        r = $urandom_range(0, 9);
        if (r < 2) return 4'd0;
        if (r < 8) return 4'(1 << $urandom_range(0, 3));
        return 4'($urandom);
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            ack_i      = 1'($urandom);
            ack_d      = 1'($urandom);
            min_diff_i = 4'($urandom);
            min_sad_i  = 16'($urandom);
            tick();
        end
        ack_i = 1'b0;
        ack_d = 1'b0;
    endtask

    task automatic run(input int cy, input int cx, input bit lit, input int ly0, input int lx0,
                       input int ly, input int lx, input int lsad, input int ln, input int abort_it);
        int py, px, it, dy, dx, ny, nx, s;
        logic [3:0] d;
        bit sup, fin;
        dut_nreq = 0;
        req = 1'b1;
        tick();
        req = 1'b0;
        e_req_d = 1'b1;
        tick();
        e_req_d = 1'b0;
        repeat ($urandom_range(0, 3)) begin
            ack_i      = 1'($urandom);
            min_diff_i = 4'($urandom);
            tick();
        end
        ack_i      = 1'b0;
        ack_d      = 1'b1;
        min_mvec_d = pkc(cy, cx);
        tick();
        ack_d      = 1'b0;
        min_mvec_d = 10'($urandom);
        py = clampc(cy);
        px = clampc(cx);
        it = 0;
        e_req_i = 1'b1;
        e_fine  = 1'b1;
        e_pos   = pk(py, px);
        if (lit) chk("lit_start", 32'(init_pos_i), 32'(pk(ly0, lx0)));
        fin = 1'b0;
        while (!fin) begin
            tick();
            e_req_i = 1'b0;
            repeat ($urandom_range(0, 3)) begin
                req   = 1'($urandom);
                ack_d = 1'($urandom);
                tick();
            end
            req   = 1'b0;
            ack_d = 1'b0;
            if (it == abort_it) begin
                rst_n  = 1'b0;
                e_req_i = 1'b0; e_ack = 1'b0; e_fine = 1'b0;
                e_mvec = '0; e_sad = '0; e_iter = 4'd0;
                tick();
                rst_n = 1'b1;
                ack_i = 1'b1;
                min_diff_i = 4'b0001;
                tick();
                ack_i = 1'b0;
                return;
            end
            d = (diff_q.size() > 0) ? diff_q.pop_front() : rand_diff();
            s = (sad_q.size() > 0) ? sad_q.pop_front() : int'($urandom_range(0, 65535));
            ack_i      = 1'b1;
            min_diff_i = d;
            min_sad_i  = 16'(s);
            dy = 0;
            dx = 0;
            if (d[3]) dy = -1;
            else if (d[2]) dy = 1;
            else if (d[1]) dx = -1;
            else if (d[0]) dx = 1;
            ny = py + dy;
            nx = px + dx;
            sup = (ny < -SR) || (ny > SR) || (nx < -SR) || (nx > SR);
            if (!sup) begin
                py = ny;
                px = nx;
            end
            it++;
            fin = (d == 4'd0) || sup || (it == MAX_ITER);
            tick();
            ack_i      = 1'b0;
            min_diff_i = 4'($urandom);
            min_sad_i  = 16'($urandom);
            if (fin) begin
                e_ack  = 1'b1;
                e_mvec = pk(py, px);
                e_sad  = 16'(s);
                e_iter = 4'(it);
                e_fine = 1'b0;
            end else begin
                e_req_i = 1'b1;
                e_pos   = pk(py, px);
            end
        end
        tick();
        e_ack = 1'b0;
        if (lit) begin
            chk("lit_mvec", 32'(min_mvec), 32'(pk(ly, lx)));
            chk("lit_sad", 32'(min_sad), 32'(lsad));
            chk("lit_nreq", 32'(dut_nreq), 32'(ln));
`ifdef ME_ITER_CNT_EN
            chk("lit_iter_cnt", 32'(iter_cnt), 32'(ln));
`endif
        end
    endtask

    initial begin
        req = 1'b0; ack_d = 1'b0; ack_i = 1'b0; rst_n = 1'b0;
        min_mvec_d = '0; min_sad_i = '0; min_diff_i = 4'd0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_mvec", 32'(min_mvec), 32'd0);
        idle(3);

        diff_q = '{4'b0001, 4'b0001, 4'b0000};
        sad_q  = '{500, 420, 400};
        run(-2, 3, 1'b1, -4, 6, -4, 8, 400, 3, -1);
        idle(2);

        diff_q = '{4'b0000};
        sad_q  = '{77};
        run(-16, 15, 1'b1, -15, 15, -15, 15, 77, 1, -1);

        diff_q = '{4'b1000, 4'b1000, 4'b1000, 4'b1000};
        sad_q  = '{90, 90, 90, 90};
        run(0, 0, 1'b1, 0, 0, -4, 0, 90, 4, -1);

        diff_q = '{4'b0001};
        sad_q  = '{33};
        run(0, 8, 1'b1, 0, 15, 0, 15, 33, 1, -1);

        diff_q = '{4'b0110, 4'b0000};
        sad_q  = '{50, 40};
        run(0, 0, 1'b1, 0, 0, 1, 0, 40, 2, -1);

        // Abort in F_WAIT of the second iteration, then a normal run.
        diff_q = '{4'b0001};
        sad_q  = '{10};
        run(3, -3, 1'b0, 0, 0, 0, 0, 0, 0, 1);
        chk("abort_mvec", 32'(min_mvec), 32'd0);
        chk("abort_sad", 32'(min_sad), 32'd0);
        diff_q.delete();
        sad_q.delete();
        idle(2);
        diff_q = '{4'b0010, 4'b0000};
        sad_q  = '{12, 11};
        run(1, 1, 1'b1, 2, 2, 2, 1, 11, 2, -1);

        repeat (200) begin
            idle($urandom_range(0, 2));
            run(int'($urandom_range(0, 31)) - 16, int'($urandom_range(0, 31)) - 16,
                1'b0, 0, 0, 0, 0, 0, 0, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
